uart_rx_fifo_feeder: RTL



---
 rtl/fifo_pkg.sv | 14 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_fifo_feeder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the UART receiver that feeds the 16x8 FIFO write port.
package fifo_pkg;

    localparam int FIFO_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 1 (idle line).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// UART receiver that writes each good byte into a FIFO, dropping bytes on full
// (sticky overrun) and bad stop bits (sticky frame_err).
module uart_rx_fifo_feeder
    import fifo_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DATA_W  = FIFO_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              full,
    output logic              wr,
    output logic [DATA_W-1:0] din,
    output logic              overrun,
    output logic              frame_err,
    input  logic              clr_err
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    rx_state_t          r_state,     w_state_next;
    logic [DIV_W-1:0]   r_div,       w_div_next;
    logic [BIT_W-1:0]   r_bit,       w_bit_next;
    logic [DATA_W-1:0]  r_shift,     w_shift_next;
    logic [DATA_W-1:0]  r_din,       w_din_next;
    logic               r_wr,        w_wr_next;
    logic               r_overrun,   w_overrun_next;
    logic               r_frame_err, w_frame_err_next;
    logic               w_rx_s;

    sync_2ff u_rx_sync (
        .clk   (clk),
        .rst_n (rst),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_din       <= '0;
            r_wr        <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_div       <= w_div_next;
            r_bit       <= w_bit_next;
            r_shift     <= w_shift_next;
            r_din       <= w_din_next;
            r_wr        <= w_wr_next;
            r_overrun   <= w_overrun_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_div_next       = r_div + 1'b1;
        w_bit_next       = r_bit;
        w_shift_next     = r_shift;
        w_din_next       = r_din;
        w_wr_next        = 1'b0;
        // Clear is applied first so a same-cycle set event below overrides it.
        w_overrun_next   = clr_err ? 1'b0 : r_overrun;
        w_frame_err_next = clr_err ? 1'b0 : r_frame_err;

        case (r_state)
            IDLE: begin
                w_div_next = '0;
                w_bit_next = '0;
                if (!w_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_div == DIV_HALF) begin
                    w_div_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_div == DIV_LAST) begin
                    w_div_next   = '0;
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    w_shift_next = {w_rx_s, r_shift[DATA_W-1:1]};
                    if (r_bit == BIT_LAST) begin
                        w_bit_next   = '0;
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end
            end
            STOP: begin
                if (r_div == DIV_LAST) begin
                    w_div_next = '0;
                    w_bit_next = '0;
                    if (!w_rx_s) begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = BREAK;
                    end else if (full) begin
                        w_overrun_next = 1'b1;
                        w_state_next   = IDLE;
                    end else begin
                        w_wr_next    = 1'b1;
                        w_din_next   = r_shift;
                        w_state_next = IDLE;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger START.
                w_div_next = '0;
                w_bit_next = '0;
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_div_next   = '0;
                w_bit_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign wr        = r_wr;
    assign din       = r_din;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule
